// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the ALU operand sequencer: widths, opcodes,
// ALU select codes, instruction field positions and FSM states.
package cpu_defs_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned FIELD_W  = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned CNT_W    = 3;

  // Instruction field LSB positions
  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned DST_LSB  = 16;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC2_LSB = 0;

  localparam logic [FIELD_W-1:0] OP_LOADI = 8'h00;
  localparam logic [FIELD_W-1:0] OP_MOV   = 8'h01;
  localparam logic [FIELD_W-1:0] OP_ADD   = 8'h02;
  localparam logic [FIELD_W-1:0] OP_SUB   = 8'h03;
  localparam logic [FIELD_W-1:0] OP_AND   = 8'h04;
  localparam logic [FIELD_W-1:0] OP_OR    = 8'h05;

  localparam logic [SEL_W-1:0] SEL_FWD = 3'b000;
  localparam logic [SEL_W-1:0] SEL_ADD = 3'b001;
  localparam logic [SEL_W-1:0] SEL_AND = 3'b010;
  localparam logic [SEL_W-1:0] SEL_OR  = 3'b011;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  // Two's-complement negate, modulo 2^DATA_W
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return DATA_W'(~v + DATA_W'(1));
  endfunction

endpackage

// File: rtl/reg_file.sv
// 8x8 register file: two combinational read ports, one synchronous write
// port, synchronous active-low clear.
module reg_file
  import cpu_defs_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Clear on reset, otherwise write one register when enabled
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand-side partner of the 8-bit ALU: accepts one instruction, drives
// the ALU operands for the op latency, then writes RESULT back.
module alu_op_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int unsigned ADD_LAT   = 2,
  parameter int unsigned LOGIC_LAT = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  input  logic [DATA_W-1:0]  RESULT,
  output logic [DATA_W-1:0]  DATA1,
  output logic [DATA_W-1:0]  DATA2,
  output logic [SEL_W-1:0]   SELECT,
  output logic               WB_VALID,
  output logic [REG_AW-1:0]  WB_ADDR,
  output logic [DATA_W-1:0]  WB_DATA,
  output logic               ILLEGAL,
  output logic               BUSY
);

  localparam logic [CNT_W-1:0] ADD_CNT   = CNT_W'(ADD_LAT);
  localparam logic [CNT_W-1:0] LOGIC_CNT = CNT_W'(LOGIC_LAT);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  data1_q, data2_q;
  logic [SEL_W-1:0]   sel_q;
  logic [REG_AW-1:0]  dest_q;
  logic               wb_valid_q, illegal_q;
  logic [REG_AW-1:0]  wb_addr_q;
  logic [DATA_W-1:0]  wb_data_q;

  logic [FIELD_W-1:0] opcode_c, imm_c;
  logic [REG_AW-1:0]  dst_c, src1_c, src2_c;
  logic [DATA_W-1:0]  rd1_c, rd2_c;
  logic               we_c;

  logic               legal_c;
  logic [SEL_W-1:0]   sel_c;
  logic [DATA_W-1:0]  d1_c, d2_c;
  logic [CNT_W-1:0]   lat_c;

  logic               unused_instr_bits;

  assign opcode_c = INSTR[OPC_LSB +: FIELD_W];
  assign imm_c    = INSTR[SRC2_LSB +: FIELD_W];
  assign dst_c    = INSTR[DST_LSB +: REG_AW];
  assign src1_c   = INSTR[SRC1_LSB +: REG_AW];
  assign src2_c   = INSTR[SRC2_LSB +: REG_AW];
  assign unused_instr_bits = ^{INSTR[23:19], INSTR[15:11]};

  assign we_c = (state_q == WB);

  reg_file u_reg_file (
    .clk_i    (CLK),
    .rst_n_i  (RESET),
    .raddr1_i (src1_c),
    .raddr2_i (src2_c),
    .rdata1_o (rd1_c),
    .rdata2_o (rd2_c),
    .we_i     (we_c),
    .waddr_i  (dest_q),
    .wdata_i  (RESULT)
  );

  // Decode the presented instruction into ALU operands, select and latency
  always_comb begin
    legal_c = 1'b1;
    sel_c   = SEL_FWD;
    d1_c    = '0;
    d2_c    = rd2_c;
    lat_c   = LOGIC_CNT;
    case (opcode_c)
      OP_LOADI: d2_c = imm_c;
      OP_MOV:   d2_c = rd2_c;
      OP_ADD: begin sel_c = SEL_ADD; d1_c = rd1_c; lat_c = ADD_CNT; end
      OP_SUB: begin sel_c = SEL_ADD; d1_c = rd1_c; d2_c = negate(rd2_c); lat_c = ADD_CNT; end
      OP_AND: begin sel_c = SEL_AND; d1_c = rd1_c; end
      OP_OR:  begin sel_c = SEL_OR;  d1_c = rd1_c; end
      default: legal_c = 1'b0;
    endcase
  end

  // Sequencer FSM: accept in IDLE, count out the latency in EXEC, write back in WB
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      sel_q      <= SEL_FWD;
      dest_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (INSTR_VALID) begin
            if (legal_c) begin
              data1_q <= d1_c;
              data2_q <= d2_c;
              sel_q   <= sel_c;
              dest_q  <= dst_c;
              cnt_q   <= lat_c;
              state_q <= EXEC;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= WB;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        WB: begin
          wb_valid_q <= 1'b1;
          wb_addr_q  <= dest_q;
          wb_data_q  <= RESULT;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Latency parameters must be non-zero and fit the counter
  always_ff @(posedge CLK) begin
    assert (ADD_LAT >= 1 && ADD_LAT <= 7 && LOGIC_LAT >= 1 && LOGIC_LAT <= 7)
      else $error("alu_op_sequencer: latency parameter outside 1..7");
  end

  assign INSTR_READY = (state_q == IDLE) && RESET;
  assign BUSY        = (state_q != IDLE);
  assign DATA1       = data1_q;
  assign DATA2       = data2_q;
  assign SELECT      = sel_q;
  assign WB_VALID    = wb_valid_q;
  assign WB_ADDR     = wb_addr_q;
  assign WB_DATA     = wb_data_q;
  assign ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: timeline reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_alu_op_sequencer;

  localparam int ADD_LAT   = 2;
  localparam int LOGIC_LAT = 1;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  RESULT;
  logic [7:0]  DATA1, DATA2;
  logic [2:0]  SELECT;
  logic        WB_VALID;
  logic [2:0]  WB_ADDR;
  logic [7:0]  WB_DATA;
  logic        ILLEGAL;
  logic        BUSY;

  alu_op_sequencer #(.ADD_LAT(ADD_LAT), .LOGIC_LAT(LOGIC_LAT)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .RESULT(RESULT), .DATA1(DATA1), .DATA2(DATA2),
    .SELECT(SELECT), .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .ILLEGAL(ILLEGAL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Simple ALU model feeding RESULT
  always_comb begin
    case (SELECT)
      3'b000:  RESULT = DATA2;
      3'b001:  RESULT = 8'(DATA1 + DATA2);
      3'b010:  RESULT = DATA1 & DATA2;
      3'b011:  RESULT = DATA1 | DATA2;
      default: RESULT = 8'h00;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 0;
  bit sim_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: an accepted op is busy until its write-back edge
  int          cyc = 0;
  bit          m_busy;
  int          m_wb_edge;
  logic [7:0]  m_regs [8];
  logic [7:0]  m_d1, m_d2, m_res, m_wbd;
  logic [2:0]  m_sel, m_dst, m_wba;
  bit          m_wbv, m_ill;

  task automatic model_accept(input logic [31:0] ins);
    logic [7:0] a, b, imm;
    int lat;
    a   = m_regs[ins[10:8]];
    b   = m_regs[ins[2:0]];
    imm = ins[7:0];
    lat = LOGIC_LAT;
    case (ins[31:24])
      8'h00: begin m_sel = 3'd0; m_d1 = 8'h00; m_d2 = imm; m_res = imm; end
      8'h01: begin m_sel = 3'd0; m_d1 = 8'h00; m_d2 = b;   m_res = b;   end
      8'h02: begin m_sel = 3'd1; m_d1 = a; m_d2 = b;          m_res = 8'(a + b); lat = ADD_LAT; end
      8'h03: begin m_sel = 3'd1; m_d1 = a; m_d2 = 8'(0 - b);  m_res = 8'(a - b); lat = ADD_LAT; end
      8'h04: begin m_sel = 3'd2; m_d1 = a; m_d2 = b;          m_res = a & b; end
      8'h05: begin m_sel = 3'd3; m_d1 = a; m_d2 = b;          m_res = a | b; end
      default: begin m_ill = 1'b1; return; end
    endcase
    m_dst     = ins[18:16];
    m_busy    = 1'b1;
    m_wb_edge = cyc + lat + 1;
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      if (!RESET) begin
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_busy = 0; m_d1 = 0; m_d2 = 0; m_sel = 0;
        m_wbv = 0; m_wba = 0; m_wbd = 0; m_ill = 0; m_dst = 0;
      end else begin
        m_wbv = 0;
        m_ill = 0;
        if (m_busy) begin
          if (cyc == m_wb_edge) begin
            m_regs[m_dst] = m_res;
            m_wbv = 1; m_wba = m_dst; m_wbd = m_res;
            m_busy = 0;
          end
        end else if (INSTR_VALID) begin
          model_accept(INSTR);
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  initial begin
    wait (cmp_en);
    while (!sim_done) begin
      @(negedge CLK);
      #2;
      check("ready",    32'(INSTR_READY), 32'(!m_busy && RESET));
      check("busy",     32'(BUSY),        32'(m_busy));
      check("wb_valid", 32'(WB_VALID),    32'(m_wbv));
      check("wb_addr",  32'(WB_ADDR),     32'(m_wba));
      check("wb_data",  32'(WB_DATA),     32'(m_wbd));
      check("illegal",  32'(ILLEGAL),     32'(m_ill));
      check("data1",    32'(DATA1),       32'(m_d1));
      check("data2",    32'(DATA2),       32'(m_d2));
      check("select",   32'(SELECT),      32'(m_sel));
    end
  end

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [7:0] s2);
    return {op, 5'b0, d, 5'b0, s1, s2};
  endfunction

  // Issue one instruction; report operands seen after accept, the edge index
  // (from accept) at which WB_VALID is sampled high, and ready-low cycles
  task automatic run_op(input logic [31:0] ins, output int lat, output logic [7:0] d1,
                        output logic [7:0] d2, output logic [2:0] sel, output logic [7:0] wbd,
                        output int low, output logic ill, output logic bsy);
    int k, acc;
    @(negedge CLK);
    INSTR = ins; INSTR_VALID = 1'b1;
    k = 0;
    while (!INSTR_READY && k < 50) begin @(negedge CLK); k++; end
    if (k >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1; acc = cyc;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    d1 = DATA1; d2 = DATA2; sel = SELECT; ill = ILLEGAL; bsy = BUSY;
    lat = 0; low = 0; wbd = 8'h00;
    for (k = 0; k < 20; k++) begin
      if (WB_VALID) begin lat = cyc - acc + 1; wbd = WB_DATA; end
      if (INSTR_READY) break;
      low++;
      @(negedge CLK);
    end
    if (k >= 20) check("wb_timeout", 32'd0, 32'd1);
  endtask

  int lat, low, nacc, nwb;
  logic [7:0] d1, d2, wbd;
  logic [2:0] sel;
  logic ill, bsy, acc_next;
  logic [31:0] prog [3];
  int wb_cyc [3];
  logic [7:0] wb_dat [3];

  initial begin
    RESET = 1'b0; INSTR = '0; INSTR_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    cmp_en = 1;
    @(negedge CLK); #1;
    check("rst_ready", 32'(INSTR_READY), 32'd0);
    check("rst_data1", 32'(DATA1), 32'h00);
    check("rst_wbv",   32'(WB_VALID), 32'd0);
    check("rst_busy",  32'(BUSY), 32'd0);
    RESET = 1'b1;

    // loadi r2,0x2A then read r2 back through mov
    run_op(mk(8'h00, 3'd2, 3'd5, 8'h2A), lat, d1, d2, sel, wbd, low, ill, bsy);
    check("loadi_d2", 32'(d2), 32'h2A);
    check("loadi_sel", 32'(sel), 32'd0);
    check("loadi_lat", 32'(lat), 32'd3);
    check("loadi_wbd", 32'(wbd), 32'h2A);
    check("loadi_wba", 32'(WB_ADDR), 32'd2);
    run_op(mk(8'h01, 3'd7, 3'd0, 8'h02), lat, d1, d2, sel, wbd, low, ill, bsy);
    check("readback_r2", 32'(d2), 32'h2A);

    // sub r3,r1,r2 with r1=5, r2=3
    run_op(mk(8'h00, 3'd1, 3'd0, 8'h05), lat, d1, d2, sel, wbd, low, ill, bsy);
    run_op(mk(8'h00, 3'd2, 3'd0, 8'h03), lat, d1, d2, sel, wbd, low, ill, bsy);
    run_op(mk(8'h03, 3'd3, 3'd1, 8'h02), lat, d1, d2, sel, wbd, low, ill, bsy);
    check("sub_d1", 32'(d1), 32'h05);
    check("sub_d2", 32'(d2), 32'hFD);
    check("sub_sel", 32'(sel), 32'd1);
    check("sub_wbd", 32'(wbd), 32'h02);
    check("sub_lat", 32'(lat), 32'd4);
    check("sub_ready_low", 32'(low), 32'd3);

    // add r1,r1,r1 with carry dropped, then mov r4,r1
    run_op(mk(8'h00, 3'd1, 3'd0, 8'hF0), lat, d1, d2, sel, wbd, low, ill, bsy);
    run_op(mk(8'h02, 3'd1, 3'd1, 8'h01), lat, d1, d2, sel, wbd, low, ill, bsy);
    check("dbl_wbd", 32'(wbd), 32'hE0);
    run_op(mk(8'h01, 3'd4, 3'd0, 8'h01), lat, d1, d2, sel, wbd, low, ill, bsy);
    check("mov_fwd_wbd", 32'(wbd), 32'hE0);

    // illegal opcode followed by a held loadi
    @(negedge CLK);
    INSTR = mk(8'h07, 3'd1, 3'd1, 8'h01); INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    INSTR = mk(8'h00, 3'd6, 3'd0, 8'h5A);
    #1;
    check("ill_pulse", 32'(ILLEGAL), 32'd1);
    check("ill_busy", 32'(BUSY), 32'd0);
    check("ill_ready", 32'(INSTR_READY), 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    check("ill_one_cycle", 32'(ILLEGAL), 32'd0);
    check("ill_next_accepted", 32'(BUSY), 32'd1);
    repeat (4) @(negedge CLK);

    // reset during EXEC of and r0,r1,r2
    @(negedge CLK);
    INSTR = mk(8'h04, 3'd0, 3'd1, 8'h02); INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    check("and_busy", 32'(BUSY), 32'd1);
    RESET = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK); #1;
    check("abort_wbv", 32'(WB_VALID), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_ready", 32'(INSTR_READY), 32'd0);
    check("abort_sel", 32'(SELECT), 32'd0);
    RESET = 1'b1;
    run_op(mk(8'h01, 3'd7, 3'd0, 8'h01), lat, d1, d2, sel, wbd, low, ill, bsy);
    check("abort_r1_zero", 32'(d2), 32'h00);
    run_op(mk(8'h01, 3'd7, 3'd0, 8'h04), lat, d1, d2, sel, wbd, low, ill, bsy);
    check("abort_r4_zero", 32'(d2), 32'h00);

    // three instructions with VALID held high
    prog[0] = mk(8'h00, 3'd5, 3'd0, 8'h11);
    prog[1] = mk(8'h02, 3'd6, 3'd5, 8'h05);
    prog[2] = mk(8'h05, 3'd7, 3'd6, 8'h05);
    nacc = 0; nwb = 0;
    @(negedge CLK);
    INSTR = prog[0]; INSTR_VALID = 1'b1;
    for (int k = 0; k < 40; k++) begin
      acc_next = INSTR_VALID && INSTR_READY;
      @(posedge CLK); #1;
      @(negedge CLK);
      if (WB_VALID && nwb < 3) begin wb_cyc[nwb] = cyc; wb_dat[nwb] = WB_DATA; nwb++; end
      if (acc_next) begin
        nacc++;
        if (nacc < 3) INSTR = prog[nacc];
        else INSTR_VALID = 1'b0;
      end
      if (nwb == 3) break;
    end
    INSTR_VALID = 1'b0;
    check("held_accepts", 32'(nacc), 32'd3);
    check("held_wbs", 32'(nwb), 32'd3);
    check("held_gap_add", 32'(wb_cyc[1] - wb_cyc[0]), 32'd4);
    check("held_gap_or", 32'(wb_cyc[2] - wb_cyc[1]), 32'd3);
    check("held_res0", 32'(wb_dat[0]), 32'h11);
    check("held_res1", 32'(wb_dat[1]), 32'h22);
    check("held_res2", 32'(wb_dat[2]), 32'h33);

    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK);
      RESET       = ($urandom_range(0, 99) != 0);
      INSTR_VALID = ($urandom_range(0, 2) != 0);
      INSTR       = $urandom;
      INSTR[31:24] = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
    end
    @(negedge CLK);
    RESET = 1'b1; INSTR_VALID = 1'b0;
    repeat (10) @(negedge CLK);

    sim_done = 1;
    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Operand-side partner of the 8-bit ALU. Accepts one 32-bit instruction at a time over a valid/ready handshake and reads source operands from an internal 8x8 register file.
- Drives the ALU inputs DATA1, DATA2 and SELECT, waits the op's latency, then writes the ALU RESULT back to the destination register.
- Sits between the instruction fetch stage and the ALU; forms the execute/write-back loop of the single-cycle-class CPU.

Parameters:
- ADD_LAT, 2, cycles waited in EXEC for SELECT=001 (add/sub); legal range 1..7
- LOGIC_LAT, 1, cycles waited in EXEC for SELECT=000/010/011; legal range 1..7

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  synchronous, active-low reset; sampled on rising CLK
- INSTR  in  32  [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2 or immediate; register addresses use bits [2:0] of each field
- INSTR_VALID  in  1  instruction present
- INSTR_READY  out  1  sequencer can accept; transfer when VALID&READY on a rising edge
- RESULT  in  8  ALU output
- DATA1  out  8  ALU operand 1
- DATA2  out  8  ALU operand 2
- SELECT  out  3  ALU function select
- WB_VALID  out  1  one-cycle pulse on register write
- WB_ADDR  out  3  register written
- WB_DATA  out  8  value written
- ILLEGAL  out  1  one-cycle pulse on unsupported opcode
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (RESET=0 at edge): state IDLE, all 8 registers = 0, DATA1=DATA2=0, SELECT=000, WB_VALID=0, WB_ADDR=0, WB_DATA=0, ILLEGAL=0, BUSY=0, latency counter=0. INSTR_READY is 0 while RESET=0.
- Reset mid-operation: aborts immediately; no write-back; any pending ILLEGAL pulse is suppressed.

Opcode map (opcode -> SELECT, DATA1, DATA2):
- 0x00 loadi -> 000, DATA1=0, DATA2=imm
- 0x01 mov -> 000, DATA1=0, DATA2=R[src2]
- 0x02 add -> 001, DATA1=R[src1], DATA2=R[src2]
- 0x03 sub -> 001, DATA1=R[src1], DATA2=(~R[src2]+1) mod 256
- 0x04 and -> 010, DATA1=R[src1], DATA2=R[src2]
- 0x05 or -> 011, DATA1=R[src1], DATA2=R[src2]
- any other opcode -> illegal

State machine:
- IDLE: INSTR_READY=1. On handshake:
  - Legal opcode: register DATA1/DATA2/SELECT and the dest address; load counter with ADD_LAT (SELECT=001) or LOGIC_LAT (otherwise); go to EXEC.
  - Illegal opcode: assert ILLEGAL for exactly the next cycle; DATA1/DATA2/SELECT hold previous values; stay in IDLE. INSTR_READY stays 1, so back-to-back instructions are accepted.
- EXEC: INSTR_READY=0. Counter decrements each cycle; on the cycle it reaches 1, go to WB. DATA1/DATA2/SELECT are held stable for the whole of EXEC.
- WB: on this edge R[dest]<=RESULT, WB_VALID=1 for one cycle with WB_ADDR=dest and WB_DATA=RESULT; go to IDLE.

Timing and arithmetic:
- Accept-to-WB_VALID latency: 1 + LAT + 1 edges, i.e. 4 cycles for add/sub and 3 for logic/move at default parameters.
- Throughput: one instruction per LAT+2 cycles.
- All arithmetic is 8-bit modulo; carry is discarded. Sub of 0 gives DATA2=0x00.

Register file and boundaries:
- Register reads are combinational from current contents at the accept edge.
- Write-back becomes visible to the next accepted instruction: dest==src of the following instruction reads the new value, with no forwarding needed.
- dest==src1==src2 within one instruction is legal (e.g. add r1,r1,r1 doubles r1).
- INSTR_VALID while BUSY is ignored; INSTR may change freely when INSTR_READY=0.
- Opcode 0x00 ignores src1/src2; opcode 0x01 ignores src1.
- An out-of-range parameter is a configuration error; the RTL carries an assertion that fires on it.

Decomposition:
- Shared package cpu_defs_pkg:
  - opcode constants OP_LOADI..OP_OR
  - ALU select constants SEL_FWD=000, SEL_ADD=001, SEL_AND=010, SEL_OR=011
  - instruction field bit positions
  - state enum {IDLE, EXEC, WB}
- One sub-module: reg_file (8x8, two combinational read ports, one synchronous write port, synchronous active-low clear on RESET).
- Decode, FSM and counter live in alu_op_sequencer.

Test Plan:
- Reset then loadi r2,0x2A -> DATA2=0x2A, SELECT=000 from the cycle after accept; with a bench ALU model, WB_VALID at accept+3 with WB_ADDR=2, WB_DATA=0x2A; register readback 0x2A.
- r1=0x05, r2=0x03, sub r3,r1,r2 -> DATA1=0x05, DATA2=0xFD, SELECT=001; WB_DATA=0x02 at accept+4; INSTR_READY=0 for 3 cycles.
- r1=0xF0, add r1,r1,r1 -> WB_DATA=0xE0 (carry dropped); an immediately following mov r4,r1 writes r4=0xE0.
- Opcode 0x07 -> ILLEGAL pulses 1 cycle, no WB_VALID, BUSY stays 0; a loadi held valid next cycle is accepted at once.
- RESET=0 asserted during EXEC of and r0,r1,r2 -> no WB_VALID; all registers read 0; outputs at reset values.
- INSTR_VALID held high continuously with 3 instructions -> exactly 3 accepts, WB_VALID pulses spaced LAT+2 cycles apart, results in order.
